multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the instruction opcode and drives every datapath enable and mux select. It is the producer of the 2-bit aluOp code that the ALU control decoder consumes.
Memory accesses use a ready handshake, so the FSM stalls on slow memory. Supported instructions: R-type, LW, SW, BEQ, J, ADDI.

Parameters:
STATE_W, 4, width of the state register and of the state debug output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26] from the instruction register
memReady  in  1  memory has completed the current read/write this cycle
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if ALU zero
iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  instruction register load
memToReg  out  1  register write data: 0 = ALUOut, 1 = MDR
regDst  out  1  destination register: 0 = rt, 1 = rd
regWrite  out  1  register file write enable
aluSrcA  out  1  ALU A input: 0 = PC, 1 = register A
aluSrcB  out  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
aluOp  out  2  00 = add, 01 = sub, 10 = use funct, 11 = never driven
pcSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
illegalOp  out  1  one-cycle pulse when an unsupported opcode is decoded
state  out  STATE_W  current state, for debug

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11.
- Encodings 12-15 are illegal; if reached they go to FETCH on the next edge with all outputs 0.
- Reset: on a clk edge with reset=1, the state becomes FETCH.
  - While reset=1, every output is forced to 0 combinationally, including state.
  - Reset asserted in any state, including mid-stall, aborts that instruction; no write is issued after that edge.
- Outputs are a Moore decode of the state. The exceptions are pcWrite/irWrite in FETCH, which are qualified by memReady. Any output not listed below is 0.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite = pcWrite = memReady.
  - Stays in FETCH while memReady=0, so the PC never increments twice; goes to DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
  - 100011 (LW) or 101011 (SW) -> MEM_ADDR
  - 000000 (R-type) -> EXECUTE
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - 001000 (ADDI) -> ADDI_EXEC
  - any other opcode -> FETCH, with illegalOp=1 for this cycle only
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEM_READ if opcode=LW, else MEM_WRITE.
- MEM_READ: memRead=1, iorD=1. Holds while memReady=0; goes to MEM_WB when memReady=1.
- MEM_WB: regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
- MEM_WRITE: memWrite=1, iorD=1. Holds while memReady=0; goes to FETCH when memReady=1.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to R_WB.
- R_WB: regWrite=1, regDst=1, memToReg=0. Goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Goes to FETCH.
- JUMP: pcWrite=1, pcSource=10. Goes to FETCH.
- ADDI_EXEC: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to ADDI_WB.
- ADDI_WB: regWrite=1, regDst=0, memToReg=0. Goes to FETCH.
- Instruction latency with memReady tied to 1:
  - J and BEQ: 3 cycles.
  - R-type, ADDI and SW: 4 cycles.
  - LW: 5 cycles.
  - Each cycle memReady is low adds one cycle.
- opcode is sampled only in DECODE and MEM_ADDR; the instruction register is stable there because irWrite=0.
- Invariants:
  - memRead and memWrite are never both 1.
  - regWrite and any PC write are never both 1.
  - aluOp=11 is never driven.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - aluOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, also used by the ALU control decoder;
  - state encodings S_FETCH..S_ADDI_WB.
- One natural sub-module, control_decode: purely combinational state-to-output decode. It keeps the FSM register and next-state logic separate and testable.

Test Plan:
- Reset held 3 cycles, then released with memReady=1 -> all outputs 0 during reset. First cycle after release: state=0, memRead=1, irWrite=1, pcWrite=1, aluSrcB=01.
- opcode=000000, memReady=1 -> state sequence 0,1,6,7,0. aluOp=10 in state 6; regWrite=1 and regDst=1 in state 7.
- opcode=100011, memReady low for 2 cycles in MEM_READ -> sequence 0,1,2,3,3,3,4,0. memRead=1 and iorD=1 for all three MEM_READ cycles; regWrite=1 and memToReg=1 in state 4.
- opcode=000100, then opcode=000010 -> BEQ: sequence 0,1,8,0 with aluOp=01, pcWriteCond=1, pcSource=01. J: sequence 0,1,9,0 with pcWrite=1, pcSource=10.
- memReady=0 for 4 cycles in FETCH -> state stays 0 with pcWrite=0 and irWrite=0 throughout. A single pcWrite pulse occurs when memReady rises.
- opcode=111111 -> illegalOp=1 for exactly one cycle in DECODE, then FETCH. Separately, reset asserted in MEM_WRITE mid-stall -> memWrite=0 from that cycle and state=0 after the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Opcodes, aluOp codes, control-FSM states and control bundle for
//          the multicycle MIPS datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Shared with the ALU control decoder; 2'b11 is deliberately unused.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
// Module : control_decode
// Brief  : Combinational state-to-control decode for the multicycle FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_decode
    import mips_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                // PC and IR update only on the cycle the fetch completes.
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = 2'b11;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~is_supported(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Main control FSM of the multicycle MIPS datapath with memory
//          ready handshake and illegal-opcode reporting.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSource,
    output logic               illegalOp,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:     w_next_state = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDI_EXEC;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next_state = memReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next_state = memReady ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next_state = S_R_WB;
            S_ADDI_EXEC: w_next_state = S_ADDI_WB;
            default:     w_next_state = S_FETCH;
        endcase
    end

    control_decode u_decode (
        .state     (r_state),
        .opcode    (opcode),
        .mem_ready (memReady),
        .ctrl      (w_ctrl)
    );

    // Reset squashes every output immediately so a stalled write never lands.
    assign w_out       = reset ? '0 : w_ctrl;
    assign pcWrite     = w_out.pc_write;
    assign pcWriteCond = w_out.pc_write_cond;
    assign iorD        = w_out.ior_d;
    assign memRead     = w_out.mem_read;
    assign memWrite    = w_out.mem_write;
    assign irWrite     = w_out.ir_write;
    assign memToReg    = w_out.mem_to_reg;
    assign regDst      = w_out.reg_dst;
    assign regWrite    = w_out.reg_write;
    assign aluSrcA     = w_out.alu_src_a;
    assign aluSrcB     = w_out.alu_src_b;
    assign aluOp       = w_out.alu_op;
    assign pcSource    = w_out.pc_source;
    assign illegalOp   = w_out.illegal_op;
    assign state       = reset ? '0 : STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed self-checking bench for the multicycle control FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;
    logic [20:0] all_outs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
    );

    assign all_outs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                       memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                       pcSource, illegalOp, state};

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; memReady = 1'b1; opcode = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (all_outs !== 21'd0) begin
                n_err++;
                $display("FAIL reset_outs cyc=%0d got=%h want=0", i, all_outs);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({state, memRead, irWrite, pcWrite, aluSrcB} !== {4'd0, 1'b1, 1'b1, 1'b1, 2'b01}) begin
            n_err++;
            $display("FAIL reset_release got st=%0d mr=%b ir=%b pw=%b bsrc=%b want st=0 1 1 1 01",
                     state, memRead, irWrite, pcWrite, aluSrcB);
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'b000000; memReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (state !== exp[i]) begin
                n_err++;
                $display("FAIL rtype_state i=%0d got=%0d want=%0d", i, state, exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({aluOp, aluSrcA, aluSrcB} !== {2'b10, 1'b1, 2'b00}) begin
                    n_err++;
                    $display("FAIL rtype_exec got op=%b a=%b b=%b want 10 1 00", aluOp, aluSrcA, aluSrcB);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if ({regWrite, regDst, memToReg, pcWrite} !== 4'b1100) begin
                    n_err++;
                    $display("FAIL rtype_wb got rw=%b rd=%b m2r=%b pw=%b want 1100", regWrite, regDst, memToReg, pcWrite);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0] exp [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            memReady = rdy[i];
            #1;
            n_cmp++;
            if (state !== exp[i]) begin
                n_err++;
                $display("FAIL lw_state i=%0d got=%0d want=%0d", i, state, exp[i]);
            end
            if (exp[i] == 4'd3) begin
                n_cmp++;
                if ({memRead, iorD, memWrite} !== 3'b110) begin
                    n_err++;
                    $display("FAIL lw_memread i=%0d got mr=%b iord=%b mw=%b want 110", i, memRead, iorD, memWrite);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if ({regWrite, memToReg, regDst} !== 3'b110) begin
                    n_err++;
                    $display("FAIL lw_wb got rw=%b m2r=%b rd=%b want 110", regWrite, memToReg, regDst);
                end
            end
            if (i < 7) step();
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0] expb [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        logic [3:0] expj [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
        memReady = 1'b1;
        opcode = 6'b000100;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (state !== expb[i]) begin
                n_err++;
                $display("FAIL beq_state i=%0d got=%0d want=%0d", i, state, expb[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({aluOp, pcWriteCond, pcSource, pcWrite} !== {2'b01, 1'b1, 2'b01, 1'b0}) begin
                    n_err++;
                    $display("FAIL beq_ctrl got op=%b pwc=%b src=%b pw=%b want 01 1 01 0", aluOp, pcWriteCond, pcSource, pcWrite);
                end
            end
            if (i < 3) step();
        end
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (state !== expj[i]) begin
                n_err++;
                $display("FAIL j_state i=%0d got=%0d want=%0d", i, state, expj[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({pcWrite, pcSource, regWrite} !== {1'b1, 2'b10, 1'b0}) begin
                    n_err++;
                    $display("FAIL j_ctrl got pw=%b src=%b rw=%b want 1 10 0", pcWrite, pcSource, regWrite);
                end
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expa [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        logic [3:0] exps [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        memReady = 1'b1;
        opcode = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (state !== expa[i]) begin
                n_err++;
                $display("FAIL addi_state i=%0d got=%0d want=%0d", i, state, expa[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({aluSrcA, aluSrcB, aluOp} !== {1'b1, 2'b10, 2'b00}) begin
                    n_err++;
                    $display("FAIL addi_exec got a=%b b=%b op=%b want 1 10 00", aluSrcA, aluSrcB, aluOp);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if ({regWrite, regDst, memToReg} !== 3'b100) begin
                    n_err++;
                    $display("FAIL addi_wb got rw=%b rd=%b m2r=%b want 100", regWrite, regDst, memToReg);
                end
            end
            if (i < 4) step();
        end
        opcode = 6'b101011;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (state !== exps[i]) begin
                n_err++;
                $display("FAIL sw_state i=%0d got=%0d want=%0d", i, state, exps[i]);
            end
            if (i == 3) begin
                n_cmp++;
                if ({memWrite, iorD, memRead} !== 3'b110) begin
                    n_err++;
                    $display("FAIL sw_write got mw=%b iord=%b mr=%b want 110", memWrite, iorD, memRead);
                end
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_fetch_stall();
        opcode = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            memReady = (i == 4);
            #1;
            n_cmp++;
            if ({state, pcWrite, irWrite, memRead} !== {4'd0, (i == 4), (i == 4), 1'b1}) begin
                n_err++;
                $display("FAIL fetch_stall i=%0d got st=%0d pw=%b ir=%b mr=%b", i, state, pcWrite, irWrite, memRead);
            end
            step();
        end
        #1;
        n_cmp++;
        if ({state, pcWrite, irWrite} !== {4'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL fetch_single_pulse got st=%0d pw=%b ir=%b want 1 0 0", state, pcWrite, irWrite);
        end
        step();
        step();
    endtask

    task automatic test_illegal_and_abort();
        opcode = 6'b111111; memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({state, illegalOp} !== {((i == 1) ? 4'd1 : 4'd0), (i == 1)}) begin
                n_err++;
                $display("FAIL illegal i=%0d got st=%0d ill=%b", i, state, illegalOp);
            end
            if (i < 2) step();
        end
        opcode = 6'b101011;
        step(); step(); step();
        memReady = 1'b0;
        step();
        #1;
        n_cmp++;
        if ({state, memWrite} !== {4'd5, 1'b1}) begin
            n_err++;
            $display("FAIL abort_stall got st=%0d mw=%b want 5 1", state, memWrite);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({state, memWrite} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_forced got st=%0d mw=%b want 0 0", state, memWrite);
        end
        step();
        reset = 1'b0; memReady = 1'b1;
        #1;
        n_cmp++;
        if ({state, memWrite, memRead} !== {4'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL abort_after got st=%0d mw=%b mr=%b want 0 0 1", state, memWrite, memRead);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_cmp++;
            if ((memRead & memWrite) || (regWrite & (pcWrite | pcWriteCond)) || (aluOp === 2'b11)) begin
                n_err++;
                $display("FAIL invariant st=%0d mr=%b mw=%b rw=%b pw=%b pwc=%b op=%b",
                         state, memRead, memWrite, regWrite, pcWrite, pcWriteCond, aluOp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branch_jump();
        test_back_to_back();
        test_fetch_stall();
        test_illegal_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
